ecc_scrub_ctrl: RTL and testbench

ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

---
 rtl/ecc_scrub_pkg.sv | 17 +
 rtl/ecc_scrub_satcnt.sv | 27 ++
 rtl/ecc_scrub_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_scrub_pkg.sv
// ECC scrub controller shared types and constants.
// Optional DED interrupt is enabled with ECC_SCRUB_IRQ_EN.
package ecc_scrub_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_CHECK,
    S_WB_REQ,
    S_NEXT
  } state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/ecc_scrub_satcnt.sv
// Saturating event counter with asynchronous clear.
module ecc_scrub_satcnt
  import ecc_scrub_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background ECC scrubber: read, check, write back corrected words.
// Define ECC_SCRUB_IRQ_EN to build the sticky DED interrupt.
module ecc_scrub_ctrl
  import ecc_scrub_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ecc_en_i,
  input  logic              start_i,
  input  logic              stop_i,
  output logic              req_o,
  input  logic              gnt_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  input  logic [31:0]       rdata_i,
  input  logic              sec_i,
  input  logic              ded_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       sec_cnt_o,
  output logic [15:0]       ded_cnt_o,
  output logic [ADDR_W-1:0] ded_addr_o,
  output logic              irq_o
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ded_addr_q, ded_addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        wait_q, wait_d;
  logic              stop_pend_q, stop_pend_d;
  logic              stop_req, last;
  logic              sec_inc, ded_inc;

  // Stop requests are latched so they wait for a safe point.
  assign stop_req = stop_i | stop_pend_q | ~ecc_en_i;
  assign last     = (addr_q == '1);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ded_addr_d  = ded_addr_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    stop_pend_d = (state_q != S_IDLE) & stop_req;
    sec_inc     = 1'b0;
    ded_inc     = 1'b0;
    req_o       = 1'b0;
    we_o        = 1'b0;
    done_o      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && ecc_en_i) begin
          state_d = S_RD_REQ;
          addr_d  = '0;
        end
      end
      S_RD_REQ: begin
        req_o = 1'b1;
        if (gnt_i) begin
          wait_d  = 3'(RD_LAT - 1);
          state_d = (RD_LAT == 1) ? S_CHECK : S_RD_WAIT;
        end else if (stop_req) begin
          state_d     = S_IDLE;
          stop_pend_d = 1'b0;
          done_o      = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (wait_q <= 3'd1) state_d = S_CHECK;
        else                wait_d  = wait_q - 3'd1;
      end
      S_CHECK: begin
        if (ded_i) begin
          ded_inc    = 1'b1;
          ded_addr_d = addr_q;
          state_d    = S_NEXT;
        end else if (sec_i) begin
          sec_inc = 1'b1;
          wdata_d = rdata_i;
          state_d = S_WB_REQ;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WB_REQ: begin
        req_o = 1'b1;
        we_o  = 1'b1;
        if (gnt_i) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (last || stop_req) begin
          state_d     = S_IDLE;
          stop_pend_d = 1'b0;
          done_o      = 1'b1;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_RD_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      ded_addr_q  <= '0;
      wdata_q     <= '0;
      wait_q      <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ded_addr_q  <= ded_addr_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  ecc_scrub_satcnt u_sec_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (sec_inc),
    .cnt_o   (sec_cnt_o)
  );

  ecc_scrub_satcnt u_ded_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (ded_inc),
    .cnt_o   (ded_cnt_o)
  );

`ifdef ECC_SCRUB_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if ((state_q == S_IDLE) && start_i && ecc_en_i) irq_d = 1'b0;
    if (ded_inc) irq_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign ded_addr_o = ded_addr_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl with a 4-word lane.
// Expected irq level follows ECC_SCRUB_IRQ_EN.
module tb_ecc_scrub_ctrl;

  localparam int AW  = 2;
  localparam int LAT = 2;
`ifdef ECC_SCRUB_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_n_i, ecc_en_i, start_i, stop_i, gnt_i;
  logic          req_o, we_o, busy_o, done_o, irq_o;
  logic [AW-1:0] addr_o, ded_addr_o;
  logic [31:0]   wdata_o, rdata_i;
  logic          sec_i, ded_i;
  logic [15:0]   sec_cnt_o, ded_cnt_o;

  logic [3:0]     sec_m, ded_m;
  logic [LAT-1:0] vld;
  logic [AW-1:0]  rd_log[$];
  logic [AW-1:0]  wr_addr;
  logic [31:0]    wr_data;
  int             n_wr, n_done;
  int             n_chk = 0;
  int             n_err = 0;
  int             cyc;

  always #5 clk_i = ~clk_i;

  ecc_scrub_ctrl #(.ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .ecc_en_i   (ecc_en_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .req_o      (req_o),
    .gnt_i      (gnt_i),
    .we_o       (we_o),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .rdata_i    (rdata_i),
    .sec_i      (sec_i),
    .ded_i      (ded_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .sec_cnt_o  (sec_cnt_o),
    .ded_cnt_o  (ded_cnt_o),
    .ded_addr_o (ded_addr_o),
    .irq_o      (irq_o)
  );

  // Memory model: flags valid LAT cycles after a granted read.
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) vld <= '0;
    else          vld <= {vld[LAT-2:0], req_o & gnt_i & ~we_o};
  end

  assign rdata_i = 32'hA5A5_0000 | {30'd0, addr_o};
  assign sec_i   = vld[LAT-1] & sec_m[addr_o];
  assign ded_i   = vld[LAT-1] & ded_m[addr_o];

  always @(posedge clk_i) begin
    if (req_o && gnt_i) begin
      if (we_o) begin
        n_wr    = n_wr + 1;
        wr_addr = addr_o;
        wr_data = wdata_o;
      end else begin
        rd_log.push_back(addr_o);
      end
    end
    if (done_o) n_done = n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    rd_log.delete();
    n_wr   = 0;
    n_done = 0;
  endtask

  task automatic wait_done(inout int c);
    while (!done_o && c < 400) begin
      @(negedge clk_i);
      c = c + 1;
    end
    chk("done_seen", 32'(done_o), 32'd1);
  endtask

  task automatic sweep(output int c);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    c = 1;
    wait_done(c);
    @(negedge clk_i);
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_nrd"}, 32'(rd_log.size()), 32'd4);
    for (int i = 0; i < rd_log.size(); i++) begin
      chk({tag, "_rda"}, 32'(rd_log[i]), 32'(i));
    end
  endtask

  initial begin
    rst_n_i  = 1'b0;
    ecc_en_i = 1'b1;
    start_i  = 1'b0;
    stop_i   = 1'b0;
    gnt_i    = 1'b1;
    sec_m    = '0;
    ded_m    = '0;
    clr_log();
    repeat (3) @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_sec", 32'(sec_cnt_o), 32'd0);
    chk("rst_ded", 32'(ded_cnt_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_dadr", 32'(ded_addr_o), 32'd0);
    chk("rst_wdat", wdata_o, 32'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Clean sweep: 4 x (LAT+2) cycles.
    clr_log();
    sweep(cyc);
    chk("t1_cyc", 32'(cyc), 32'd16);
    chk_seq("t1");
    chk("t1_nwr", 32'(n_wr), 32'd0);
    chk("t1_sec", 32'(sec_cnt_o), 32'd0);
    chk("t1_ded", 32'(ded_cnt_o), 32'd0);
    chk("t1_busy", 32'(busy_o), 32'd0);
    chk("t1_ndone", 32'(n_done), 32'd1);

    // Single-bit error at address 2 gets written back.
    sec_m = 4'b0100;
    clr_log();
    sweep(cyc);
    chk("t2_cyc", 32'(cyc), 32'd17);
    chk("t2_nwr", 32'(n_wr), 32'd1);
    chk("t2_wadr", 32'(wr_addr), 32'd2);
    chk("t2_wdat", wr_data, 32'hA5A5_0002);
    chk("t2_sec", 32'(sec_cnt_o), 32'd1);
    chk("t2_wdo", wdata_o, 32'hA5A5_0002);

    // DED wins over SEC at address 1: no write-back.
    sec_m = 4'b0010;
    ded_m = 4'b0010;
    clr_log();
    sweep(cyc);
    chk("t3_cyc", 32'(cyc), 32'd16);
    chk("t3_nwr", 32'(n_wr), 32'd0);
    chk("t3_ded", 32'(ded_cnt_o), 32'd1);
    chk("t3_dadr", 32'(ded_addr_o), 32'd1);
    chk("t3_sec", 32'(sec_cnt_o), 32'd1);
    chk("t3_irq", 32'(irq_o), 32'(IRQ_EXP));

    // Start with ECC disabled is ignored.
    ecc_en_i = 1'b0;
    start_i  = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    chk("t3b_busy", 32'(busy_o), 32'd0);
    chk("t3b_irq", 32'(irq_o), 32'(IRQ_EXP));
    ecc_en_i = 1'b1;

    // Grant withheld for 5 cycles on the first read.
    sec_m = '0;
    ded_m = '0;
    clr_log();
    gnt_i   = 1'b0;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 1;
    chk("t4_irqclr", 32'(irq_o), 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk("t4_req", 32'(req_o), 32'd1);
      chk("t4_we", 32'(we_o), 32'd0);
      chk("t4_addr", 32'(addr_o), 32'd0);
      @(negedge clk_i);
      cyc = cyc + 1;
    end
    gnt_i = 1'b1;
    wait_done(cyc);
    @(negedge clk_i);
    chk("t4_cyc", 32'(cyc), 32'd21);
    chk_seq("t4");

    // Stop during RD_WAIT finishes the read then ends via NEXT.
    clr_log();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("t5_req1", 32'(req_o), 32'd1);
    @(negedge clk_i);
    chk("t5_req2", 32'(req_o), 32'd0);
    stop_i = 1'b1;
    @(negedge clk_i);
    stop_i = 1'b0;
    chk("t5_done3", 32'(done_o), 32'd0);
    @(negedge clk_i);
    chk("t5_done4", 32'(done_o), 32'd1);
    @(negedge clk_i);
    chk("t5_busy", 32'(busy_o), 32'd0);
    chk("t5_nrd", 32'(rd_log.size()), 32'd1);
    chk("t5_ndone", 32'(n_done), 32'd1);

    // ECC enable dropping mid-sweep acts as stop.
    clr_log();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    ecc_en_i = 1'b0;
    @(negedge clk_i);
    ecc_en_i = 1'b1;
    @(negedge clk_i);
    chk("t6_done4", 32'(done_o), 32'd1);
    @(negedge clk_i);
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_nrd", 32'(rd_log.size()), 32'd1);

    // Preload SEC counter near the limit, then three SEC events.
    force dut.u_sec_cnt.cnt_q = 16'hFFFE;
    @(negedge clk_i);
    release dut.u_sec_cnt.cnt_q;
    @(negedge clk_i);
    chk("t7_pre", 32'(sec_cnt_o), 32'h0000_FFFE);
    sec_m = 4'b0111;
    clr_log();
    sweep(cyc);
    chk("t7_cyc", 32'(cyc), 32'd19);
    chk("t7_nwr", 32'(n_wr), 32'd3);
    chk("t7_sat", 32'(sec_cnt_o), 32'h0000_FFFF);

    // Reset while a write-back is pending.
    sec_m = 4'b0001;
    clr_log();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    gnt_i = 1'b0;
    @(negedge clk_i);
    chk("t8_wbreq", 32'(req_o), 32'd1);
    chk("t8_wbwe", 32'(we_o), 32'd1);
    chk("t8_wbadr", 32'(addr_o), 32'd0);
    #1 rst_n_i = 1'b0;
    #1;
    chk("t8_req", 32'(req_o), 32'd0);
    chk("t8_we", 32'(we_o), 32'd0);
    chk("t8_busy", 32'(busy_o), 32'd0);
    chk("t8_sec", 32'(sec_cnt_o), 32'd0);
    chk("t8_ded", 32'(ded_cnt_o), 32'd0);
    chk("t8_dadr", 32'(ded_addr_o), 32'd0);
    chk("t8_wdat", wdata_o, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    gnt_i   = 1'b1;
    @(negedge clk_i);
    chk("t8_idle", 32'(busy_o), 32'd0);
    chk("t8_ndone", 32'(n_done), 32'd0);
    chk("t8_nwr", 32'(n_wr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
